stroke_interp: RTL

Line-segment interpolator between the cursor/remote-cursor sources and the canvas frame buffer. It accepts one point per handshake (x, y, color, stroke width), for example one per frame from the user-input block or from the decoded inter-FPGA link. It emits every canvas pixel on the straight line from the previous point of the same stroke to the new one, using integer Bresenham stepping. This closes the gaps that appear when the cursor moves more than one pixel per frame, and it feeds the frame buffer's write port one pixel per cycle under ready/valid flow control.

---
 rtl/stroke_interp.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stroke_interp.sv
// +------------------------------------------------------------------------+
// | stroke_interp: Bresenham line interpolator, point stream -> pixel stream |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module stroke_interp #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int COLOR_WIDTH = 4,
  parameter int SW_WIDTH    = 3
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pt_valid_in,
  output logic                   pt_ready_out,
  input  logic [X_WIDTH-1:0]     pt_x_in,
  input  logic [Y_WIDTH-1:0]     pt_y_in,
  input  logic [COLOR_WIDTH-1:0] pt_color_in,
  input  logic [SW_WIDTH-1:0]    pt_sw_in,
  input  logic                   stroke_start_in,
  output logic                   px_valid_out,
  input  logic                   px_ready_in,
  output logic [X_WIDTH-1:0]     px_x_out,
  output logic [Y_WIDTH-1:0]     px_y_out,
  output logic [COLOR_WIDTH-1:0] px_color_out,
  output logic [SW_WIDTH-1:0]    px_sw_out,
  output logic                   busy_out
);

  localparam int DW  = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1;
  localparam int EW  = DW + 1;
  localparam int E2W = DW + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [X_WIDTH-1:0]      prev_x_q, prev_x_d, cur_x_q, cur_x_d, end_x_q, end_x_d;
  logic [Y_WIDTH-1:0]      prev_y_q, prev_y_d, cur_y_q, cur_y_d, end_y_q, end_y_d;
  logic                    has_prev_q, has_prev_d;
  logic [DW-1:0]           dx_q, dx_d;
  logic signed [DW-1:0]    dy_q, dy_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [EW-1:0]    err_q, err_d;
  logic [COLOR_WIDTH-1:0]  color_q, color_d;
  logic [SW_WIDTH-1:0]     sw_q, sw_d;

  logic signed [DW-1:0]    diff_x, diff_y, neg_y;
  logic [DW-1:0]           abs_x;
  logic signed [E2W-1:0]   e2, dx_e, dy_e;
  logic                    step_x, step_y;
  logic signed [EW-1:0]    err_inc_x, err_inc_y, err_next;

  // cur holds the start point between accept and SETUP
  assign diff_x = DW'(end_x_q) - DW'(cur_x_q);
  assign diff_y = DW'(end_y_q) - DW'(cur_y_q);
  assign abs_x  = diff_x[DW-1] ? -diff_x : diff_x;
  assign neg_y  = diff_y[DW-1] ? diff_y : -diff_y;

  assign e2        = {err_q, 1'b0};
  assign dx_e      = {{(E2W-DW){1'b0}}, dx_q};
  assign dy_e      = {{(E2W-DW){dy_q[DW-1]}}, dy_q};
  assign step_x    = (e2 >= dy_e);
  assign step_y    = (e2 <= dx_e);
  assign err_inc_x = step_x ? {dy_q[DW-1], dy_q} : '0;
  assign err_inc_y = step_y ? {1'b0, dx_q} : '0;
  assign err_next  = err_q + err_inc_x + err_inc_y;

  always_comb begin
    state_d    = state_q;
    prev_x_d   = prev_x_q;
    prev_y_d   = prev_y_q;
    has_prev_d = has_prev_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    end_x_d    = end_x_q;
    end_y_d    = end_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    sx_neg_d   = sx_neg_q;
    sy_neg_d   = sy_neg_q;
    err_d      = err_q;
    color_d    = color_q;
    sw_d       = sw_q;
    case (state_q)
      IDLE: begin
        if (pt_valid_in) begin
          end_x_d    = pt_x_in;
          end_y_d    = pt_y_in;
          color_d    = pt_color_in;
          sw_d       = pt_sw_in;
          prev_x_d   = pt_x_in;
          prev_y_d   = pt_y_in;
          has_prev_d = 1'b1;
          if (has_prev_q && !stroke_start_in) begin
            cur_x_d = prev_x_q;
            cur_y_d = prev_y_q;
          end else begin
            cur_x_d = pt_x_in;
            cur_y_d = pt_y_in;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        dx_d     = abs_x;
        dy_d     = neg_y;
        sx_neg_d = diff_x[DW-1];
        sy_neg_d = diff_y[DW-1];
        err_d    = {1'b0, abs_x} + {neg_y[DW-1], neg_y};
        state_d  = DRAW;
      end
      DRAW: begin
        if (px_ready_in) begin
          if (cur_x_q == end_x_q && cur_y_q == end_y_q) begin
            state_d = IDLE;
          end else begin
            err_d = err_next;
            if (step_x) cur_x_d = sx_neg_q ? cur_x_q - X_WIDTH'(1) : cur_x_q + X_WIDTH'(1);
            if (step_y) cur_y_d = sy_neg_q ? cur_y_q - Y_WIDTH'(1) : cur_y_q + Y_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      has_prev_q <= 1'b0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      end_x_q    <= '0;
      end_y_q    <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      err_q      <= '0;
      color_q    <= '0;
      sw_q       <= '0;
    end else begin
      state_q    <= state_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      has_prev_q <= has_prev_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      end_x_q    <= end_x_d;
      end_y_q    <= end_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      sx_neg_q   <= sx_neg_d;
      sy_neg_q   <= sy_neg_d;
      err_q      <= err_d;
      color_q    <= color_d;
      sw_q       <= sw_d;
    end
  end

  assign pt_ready_out = (state_q == IDLE);
  assign busy_out     = (state_q != IDLE);
  assign px_valid_out = (state_q == DRAW);
  assign px_x_out     = cur_x_q;
  assign px_y_out     = cur_y_q;
  assign px_color_out = color_q;
  assign px_sw_out    = sw_q;

endmodule

`default_nettype wire
